// File: rtl/cineraria_core_pout_if.sv
// cineraria_core_pout_if: Avalon-MM slave bus bundle for the output port
interface cineraria_core_pout_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master(output address, chipselect, write_n, writedata, input readdata);
  modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/cineraria_core_pout.sv
// cineraria_core_pout: Avalon-MM output port with set/clear, timed pulses and done irq
module cineraria_core_pout #(
  parameter int          WIDTH             = 8,
  parameter logic [31:0] RESET_VALUE       = 32'd0,
  parameter logic [15:0] PULSE_LEN_DEFAULT = 16'd1000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  cineraria_core_pout_if.slave bus,
  output logic [WIDTH-1:0]     out_port,
  output logic                 irq
);
  logic             wr;
  logic             wr_data, wr_set, wr_clr, wr_pulse, wr_mask, wr_done, wr_len;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] out_q, busy, done, irq_mask;
  logic [WIDTH-1:0] out_d, busy_d, done_d;
  logic [WIDTH-1:0] cancel, start;
  logic [15:0]      pulse_len, eff_len;
  logic [15:0]      cnt   [WIDTH];
  logic [15:0]      cnt_d [WIDTH];
  logic [31:0]      rd_d;
  logic             unused;

  assign unused   = ^bus.writedata;
  assign wr       = bus.chipselect & ~bus.write_n;
  assign wr_data  = wr & (bus.address == 3'd0);
  assign wr_set   = wr & (bus.address == 3'd1);
  assign wr_clr   = wr & (bus.address == 3'd2);
  assign wr_pulse = wr & (bus.address == 3'd3);
  assign wr_mask  = wr & (bus.address == 3'd4);
  assign wr_done  = wr & (bus.address == 3'd5);
  assign wr_len   = wr & (bus.address == 3'd6);
  assign wd       = bus.writedata[WIDTH-1:0];
  assign eff_len  = (pulse_len == 16'd0) ? 16'd1 : pulse_len;
  // Any direct data/set/clear on a bit overrides (and silently aborts) its pulse
  assign cancel   = {WIDTH{wr_data}} | ({WIDTH{wr_set | wr_clr}} & wd);
  assign start    = {WIDTH{wr_pulse}} & wd;
  assign out_port = out_q;
  assign irq      = |(done & irq_mask);

  // Per-bit next state: cancel beats start beats expiry beats countdown
  always_comb begin
    out_d  = out_q;
    busy_d = busy;
    done_d = wr_done ? '0 : done;
    for (int k = 0; k < WIDTH; k++) begin
      cnt_d[k] = cnt[k];
      if (cancel[k]) begin
        out_d[k]  = wr_data ? wd[k] : wr_set;
        busy_d[k] = 1'b0;
        cnt_d[k]  = 16'd0;
      end else if (start[k]) begin
        out_d[k]  = 1'b1;
        busy_d[k] = 1'b1;
        cnt_d[k]  = eff_len;
      end else if (busy[k] && cnt[k] == 16'd1) begin
        out_d[k]  = 1'b0;
        busy_d[k] = 1'b0;
        cnt_d[k]  = 16'd0;
        done_d[k] = 1'b1;
      end else if (busy[k]) begin
        cnt_d[k]  = cnt[k] - 16'd1;
      end
    end
  end

  // Read mux, registered below for one-cycle latency
  always_comb begin
    case (bus.address)
      3'd0:    rd_d = 32'(out_q);
      3'd3:    rd_d = 32'(busy);
      3'd4:    rd_d = 32'(irq_mask);
      3'd5:    rd_d = 32'(done);
      3'd6:    rd_d = {16'd0, pulse_len};
      default: rd_d = 32'd0;
    endcase
  end

  // State and read data registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q        <= RESET_VALUE[WIDTH-1:0];
      busy         <= '0;
      done         <= '0;
      irq_mask     <= '0;
      pulse_len    <= PULSE_LEN_DEFAULT;
      bus.readdata <= 32'd0;
      for (int k = 0; k < WIDTH; k++) cnt[k] <= 16'd0;
    end else begin
      out_q        <= out_d;
      busy         <= busy_d;
      done         <= done_d;
      bus.readdata <= rd_d;
      if (wr_mask) irq_mask <= wd;
      if (wr_len) pulse_len <= bus.writedata[15:0];
      for (int k = 0; k < WIDTH; k++) cnt[k] <= cnt_d[k];
    end
  end
endmodule

// File: tb/tb_cineraria_core_pout.sv
// tb_cineraria_core_pout: scoreboard bench for the output port
module tb_cineraria_core_pout;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] out_port;
  logic       irq;
  int         n_chk = 0;
  int         n_err = 0;
  logic [31:0] exp_q [$];
  logic [2:0]  adr_q [$];
  logic [31:0] exp_v;
  logic [2:0]  adr_v;

  cineraria_core_pout_if bus();

  cineraria_core_pout #(.WIDTH(8), .RESET_VALUE(32'd0), .PULSE_LEN_DEFAULT(16'd1000)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address = a;
    bus.writedata = d;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e);
    bus.address = a;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b1;
    exp_q.push_back(e);
    adr_q.push_back(a);
    tick();
    bus.chipselect = 1'b0;
  endtask

  // Reads retire one cycle after the edge that sampled them
  always @(posedge clk) begin
    if (reset_n && bus.chipselect && bus.write_n) begin
      #1;
      if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else begin
        exp_v = exp_q.pop_front();
        adr_v = adr_q.pop_front();
        check($sformatf("read_a%0d", adr_v), bus.readdata, exp_v);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    bus.address = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.writedata = 32'd0;
    repeat (3) tick();
    check("rst_out", 32'(out_port), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_readdata", bus.readdata, 32'h0);
    reset_n = 1'b1;
    rd(0, 32'h0); rd(1, 32'h0); rd(2, 32'h0); rd(3, 32'h0);
    rd(4, 32'h0); rd(5, 32'h0); rd(6, 32'd1000); rd(7, 32'h0);
    wr(0, 32'hA5);
    check("data_out", 32'(out_port), 32'hA5);
    rd(0, 32'hA5);
    // set / clear
    wr(1, 32'h0A);
    check("set_out", 32'(out_port), 32'hAF);
    wr(2, 32'h81);
    check("clr_out", 32'(out_port), 32'h2E);
    rd(1, 32'h0); rd(2, 32'h0);
    wr(7, 32'hFF);
    rd(0, 32'h2E); rd(7, 32'h0);
    // 5-cycle pulse on bit 0
    wr(6, 32'd5);
    wr(3, 32'h01);
    check("p5_e0", 32'(out_port), 32'h2F);
    rd(3, 32'h01);
    check("p5_e1", 32'(out_port), 32'h2F);
    for (int c = 2; c <= 4; c++) begin
      tick();
      check($sformatf("p5_e%0d", c), 32'(out_port), 32'h2F);
    end
    tick();
    check("p5_fall", 32'(out_port), 32'h2E);
    rd(5, 32'h01);
    rd(3, 32'h00);
    check("irq_masked", 32'(irq), 32'h0);
    wr(4, 32'h01);
    check("irq_on", 32'(irq), 32'h1);
    wr(5, 32'h0);
    check("irq_clr", 32'(irq), 32'h0);
    rd(5, 32'h0);
    // retrigger on bit 1
    wr(6, 32'd10);
    wr(3, 32'h02);
    check("rt_e0", 32'(out_port), 32'h2E);
    repeat (5) tick();
    wr(3, 32'h02);
    for (int c = 7; c <= 15; c++) begin
      tick();
      check($sformatf("rt_e%0d", c), 32'(out_port), 32'h2E);
    end
    tick();
    check("rt_fall", 32'(out_port), 32'h2C);
    rd(5, 32'h02);
    check("rt_irq_masked", 32'(irq), 32'h0);
    wr(5, 32'h0);
    // cancel by CLR mid-pulse and on expiry edge
    wr(6, 32'd8);
    wr(3, 32'h04);
    check("cx_start", 32'(out_port), 32'h2C);
    repeat (2) tick();
    wr(2, 32'h04);
    check("cx_clr", 32'(out_port), 32'h28);
    rd(3, 32'h0);
    repeat (8) tick();
    rd(5, 32'h0);
    check("cx_after", 32'(out_port), 32'h28);
    wr(3, 32'h04);
    repeat (7) tick();
    check("cxe_e7", 32'(out_port), 32'h2C);
    wr(2, 32'h04);
    check("cxe_clr", 32'(out_port), 32'h28);
    rd(5, 32'h0);
    rd(3, 32'h0);
    // zero length and done-clear racing expiry
    wr(6, 32'd0);
    wr(3, 32'h10);
    check("z_e0", 32'(out_port), 32'h38);
    tick();
    check("z_fall", 32'(out_port), 32'h28);
    rd(5, 32'h10);
    wr(4, 32'h10);
    check("z_irq", 32'(irq), 32'h1);
    wr(5, 32'h0);
    check("z_irq_clr", 32'(irq), 32'h0);
    wr(3, 32'h10);
    check("race_e0", 32'(out_port), 32'h38);
    wr(5, 32'h0);
    check("race_out", 32'(out_port), 32'h28);
    check("race_irq", 32'(irq), 32'h1);
    rd(5, 32'h10);
    // reset mid-pulse
    wr(6, 32'd100);
    wr(3, 32'h40);
    check("mr_start", 32'(out_port), 32'h68);
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    check("mr_out", 32'(out_port), 32'h0);
    check("mr_irq", 32'(irq), 32'h0);
    check("mr_readdata", bus.readdata, 32'h0);
    reset_n = 1'b1;
    rd(4, 32'h0); rd(5, 32'h0); rd(6, 32'd1000); rd(0, 32'h0); rd(3, 32'h0);
    repeat (110) tick();
    check("mr_late_out", 32'(out_port), 32'h0);
    rd(5, 32'h0);
    tick();
    check("sb_left", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cineraria_core_pout.md
Name: cineraria_core_pout

Overview:
Avalon-MM slave output port: it drives a WIDTH-bit out_port (LEDs, strobes) from CPU writes. It is the output-direction companion of the edge-capturing input PIO on the same bus. Supported writes are a full data write, atomic per-bit set and clear, and per-bit auto-clearing timed pulses. Each pulse completion is latched in a done register, which raises a maskable irq.

Parameters:
WIDTH, 8, number of output bits (1..32)
RESET_VALUE, 0, out_port value after reset
PULSE_LEN_DEFAULT, 1000, reset value of PULSE_LEN register (16-bit, clock cycles)

Ports:
clk  in  1  system clock, single clock domain
reset_n  in  1  reset, synchronous, active-low
address  in  3  register word select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  registered read data
out_port  out  WIDTH  output pins, driven straight from the data register
irq  out  1  interrupt, active-high level

Behaviour:
- Reset (reset_n=0 at a clk edge) sets the following:
  - out_port=RESET_VALUE, busy=0, all counters=0.
  - irq_mask=0, done=0, pulse_len=PULSE_LEN_DEFAULT.
  - readdata=0, irq=0.
- Write strobe: wr = chipselect & ~write_n. Writes take effect at the same clk edge. Only writedata[WIDTH-1:0] is used, except PULSE_LEN, which uses [15:0].
- Register map:
  - 0 DATA R/W: write loads out_port. Read returns out_port.
  - 1 SET W: out bits with writedata=1 are set. Read returns 0.
  - 2 CLR W: out bits with writedata=1 are cleared. Read returns 0.
  - 3 PULSE W: starts a pulse on each bit with writedata=1. Read returns busy[WIDTH-1:0].
  - 4 IRQMASK R/W.
  - 5 DONE R: returns latched completion bits. Any write clears all done bits.
  - 6 PULSE_LEN R/W: 16-bit pulse length.
  - 7: reads 0, writes ignored.
- Read path: readdata is registered every cycle from address, regardless of chipselect. Read latency is 1 cycle. Unused upper bits read 0.
- Per-bit pulse engine (bit i):
  - A PULSE write with bit i=1 sets out[i]=1 and busy[i]=1, and loads cnt[i]=max(pulse_len,1).
  - While busy[i], cnt[i] decrements by 1 each cycle.
  - On the edge where cnt[i]==1: out[i]=0, busy[i]=0, cnt[i]=0, done[i]=1.
  - Result: out[i] is high for exactly max(pulse_len,1) cycles after the write edge.
  - Retrigger: a PULSE write to a busy bit reloads cnt[i]. No done event is generated for the aborted pulse.
  - pulse_len=0 behaves as 1.
  - A PULSE_LEN write does not affect pulses already in flight.
- Cancellation: a DATA write, or a SET/CLR write with bit i=1, on a busy bit i has these effects:
  - out[i] takes the written or set/cleared value.
  - busy[i]=0, cnt[i]=0, and no done[i] event is generated.
  - This holds even if the write lands on the same edge as expiry: the write wins.
- Bits not selected by a SET/CLR/PULSE write are untouched.
- Simultaneous DONE clear and expiry on the same edge: the new done bit is set. Completion events are never lost.
- irq = |(done & irq_mask), combinational from registers. Deasserts the cycle after the done clear or mask clear edge.
- Reset mid-pulse: all pulses abort, out_port=RESET_VALUE, and no done bits are set.

Test Plan:
1. Reset, then read all addresses → DATA=RESET_VALUE, 4/5=0, 6=1000, irq=0. Write DATA=0xA5 → out_port=0xA5 the next cycle. Read 0 → 0xA5 with 1-cycle latency.
2. With out=0xA5: SET 0x0A → 0xAF. Then CLR 0x81 → 0x2E. Reads of addresses 1 and 2 → 0.
3. PULSE_LEN=5, PULSE 0x01 → out[0] high for exactly 5 cycles and busy[0]=1 during them. done[0]=1 at the falling edge. With IRQMASK=0x01, irq=1. Any DONE write → irq=0 the next cycle.
4. PULSE_LEN=10, PULSE 0x02 at t0, retrigger at t0+6 → out[1] stays high until t0+16. Exactly one done[1] set.
5. PULSE_LEN=8, PULSE 0x04, then CLR 0x04 at cycle 3 → out[2]=0 immediately after that edge, busy[2]=0, done[2] stays 0. Repeat with the CLR on the expiry edge → done[2]=0.
6. PULSE_LEN=0 → 1-cycle pulse. DONE write on the expiry edge of a second pulse → done bit remains set. Assert reset_n=0 mid-pulse → all state returns to its reset values.
